sysid_uptime: RTL and testbench
===============================

# sysid_uptime

Parametrised Avalon-MM system ID slave, successor to the fixed two-word ID block. It returns a build ID and a timestamp, and adds several registers:
- a prescaled free-running uptime counter, wider than 32 bits, read through a coherent low/high snapshot;
- control and sticky status registers;
- two scratch registers.

Software uses it to identify the hardware image and to get a monotonic time base without instantiating a separate timer.

## Interface
Parameters:
- ID, 32'h0000_0000: value returned at word 0.
- TIMESTAMP, 32'h0000_0000: build timestamp returned at word 1.
- UPTIME_WIDTH, 48: uptime counter width, legal range 33..64.
- CLK_DIV, 1000: clock cycles per uptime tick, legal range 1..65535.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address.
- read  in  1  read strobe, one cycle per access.
- write  in  1  write strobe, one cycle per access.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high for exactly one cycle, qualifying readdata.
- tick  out  1  one-cycle pulse on every uptime increment.

## Operation
Register map (word address):
- 0 ID: read-only. Writes ignored.
- 1 TIMESTAMP: read-only. Writes ignored.
- 2 UPTIME_LO: read returns uptime[31:0]. The same read copies uptime[UPTIME_WIDTH-1:32], zero-extended, into the high snapshot.
- 3 UPTIME_HI: read returns the high snapshot. Writes ignored.
- 4 CONTROL, read/write:
  - bit0 FREEZE: when 1, the prescaler and uptime counter hold.
  - bit1 CLEAR: write 1 zeroes the prescaler and uptime counter. Self-clearing; always reads 0.
  - bits 31:2 read 0.
- 5 STATUS:
  - bit0 WRAP: sticky; set when uptime wraps from all-ones to 0. Write 1 clears it.
  - bits 31:1 read 0.
- 6 SCRATCH0, read/write, 32 bits.
- 7 SCRATCH1, read/write, 32 bits.

Prescaler:
- Counts 0..CLK_DIV-1 while FREEZE=0.
- At CLK_DIV-1 it returns to 0, uptime increments by 1 and tick pulses.
- CLK_DIV=1: uptime increments every unfrozen cycle.

Simultaneous and boundary events:
- CLEAR write and tick in the same cycle: clear wins. Uptime=0, prescaler=0, tick still pulses.
- Wrap and a WRAP write-1-clear in the same cycle: set wins.
- read and write asserted together: the write executes, the read is dropped, and readdatavalid stays low.
- Reading UPTIME_HI without a prior UPTIME_LO read returns the last snapshot (0 after reset).

Reset, asynchronous and active-high, forces:
- readdata=0, readdatavalid=0, tick=0
- prescaler=0, uptime=0, snapshot=0
- FREEZE=0, WRAP=0, both scratch registers=0

Reset during an outstanding read: the read is lost, and readdatavalid stays low until a new read after reset.

## Timing
- Read latency is fixed at 1:
  - read in cycle N gives readdatavalid=1 and readdata in cycle N+1;
  - readdata holds its value until the next read.
- Back-to-back reads are accepted every cycle; there is no waitrequest.
- Writes take effect at the clock edge ending the write cycle. A read in the next cycle returns the new value.
- The UPTIME_LO read returns the counter value before any increment in that same cycle. The snapshot is taken from that same pre-increment value, so low and high are coherent.
- FREEZE written 1 in cycle N: no tick occurs in any cycle after N.
- tick is registered and coincides with the cycle in which the new uptime value is first visible.

## Test plan
- Reset, then read addresses 0..7 with ID=32'h4D09_E0CE, TIMESTAMP=32'h4B8A_1234 -> readdata 4D09E0CE, 4B8A1234, then 0 for every other address; each readdatavalid is exactly 1 cycle after its read.
- CLK_DIV=4: after reset, run 40 cycles, read UPTIME_LO -> 10. Also check tick pulses every 4th cycle.
- Preload uptime to 48'h0000_FFFF_FFFF (CLK_DIV=1), read UPTIME_LO on the wrap cycle -> LO=FFFFFFFF and HI snapshot=0. Next LO/HI pair reads 1/1.
- Run to 48'hFFFF_FFFF_FFFF, let it wrap -> STATUS=1. Issue a write-1-clear coincident with a second wrap -> STATUS stays 1. A later lone clear -> STATUS=0.
- Write FREEZE=1, wait 100 cycles -> uptime is unchanged and tick stays low. Write CLEAR=1 together with FREEZE=0 -> uptime=0 and counting resumes; CONTROL reads 0.
- Write SCRATCH0=A5A5_5A5A and SCRATCH1=1234_5678, then assert read+write together on address 6 -> no readdatavalid. Then assert reset mid-read -> both scratch registers read 0.

Source files
------------

// File: rtl/sysid_uptime.sv
// Avalon-MM system ID slave: build ID, timestamp, prescaled uptime counter with
// coherent low/high snapshot, control/status and two scratch registers.
module sysid_uptime #(
  parameter logic [31:0] ID           = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          UPTIME_WIDTH = 48,
  parameter int          CLK_DIV      = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        tick
);

  localparam logic [15:0] PS_LAST = 16'(CLK_DIV - 1);

  localparam logic [2:0] A_ID       = 3'd0;
  localparam logic [2:0] A_TS       = 3'd1;
  localparam logic [2:0] A_UP_LO    = 3'd2;
  localparam logic [2:0] A_UP_HI    = 3'd3;
  localparam logic [2:0] A_CONTROL  = 3'd4;
  localparam logic [2:0] A_STATUS   = 3'd5;
  localparam logic [2:0] A_SCRATCH0 = 3'd6;
  localparam logic [2:0] A_SCRATCH1 = 3'd7;

  logic [15:0]             prescale_q, prescale_d;
  logic [UPTIME_WIDTH-1:0] uptime_q, uptime_d;
  logic [31:0]             snap_q, snap_d;
  logic                    freeze_q, freeze_d;
  logic                    wrap_q, wrap_d;
  logic [31:0]             scratch0_q, scratch0_d;
  logic [31:0]             scratch1_q, scratch1_d;
  logic [31:0]             readdata_q, readdata_d;
  logic                    rdv_q, rdv_d;
  logic                    tick_q, tick_d;

  logic [63:0] up_ext;
  logic        rd_en;
  logic        ctrl_wr;
  logic        clear;
  logic        freeze_eff;
  logic        hit;
  logic        wrap_event;

  assign up_ext = 64'(uptime_q);

  // A write wins over a simultaneous read; the read is simply dropped.
  assign rd_en   = read & ~write;
  assign ctrl_wr = write && (address == A_CONTROL);
  assign clear   = ctrl_wr && writedata[1];

  // A FREEZE write already gates the cycle it is written in, so no tick follows it.
  assign freeze_eff = ctrl_wr ? writedata[0] : freeze_q;
  assign hit        = !freeze_eff && (prescale_q == PS_LAST);
  assign wrap_event = hit && (&uptime_q) && !clear;

  always_comb begin
    prescale_d = prescale_q;
    uptime_d   = uptime_q;
    snap_d     = snap_q;
    freeze_d   = freeze_eff;
    wrap_d     = wrap_q;
    scratch0_d = scratch0_q;
    scratch1_d = scratch1_q;
    readdata_d = readdata_q;
    rdv_d      = 1'b0;
    tick_d     = hit;

    if (clear) begin
      prescale_d = 16'd0;
      uptime_d   = '0;
    end else if (!freeze_eff) begin
      if (hit) begin
        prescale_d = 16'd0;
        uptime_d   = uptime_q + UPTIME_WIDTH'(1);
      end else begin
        prescale_d = prescale_q + 16'd1;
      end
    end

    if (write) begin
      case (address)
        A_STATUS:   if (writedata[0]) wrap_d = 1'b0;
        A_SCRATCH0: scratch0_d = writedata;
        A_SCRATCH1: scratch1_d = writedata;
        default:    ;
      endcase
    end
    // Set has priority over a coincident write-1-clear.
    if (wrap_event) wrap_d = 1'b1;

    if (rd_en) begin
      rdv_d = 1'b1;
      case (address)
        A_ID:       readdata_d = ID;
        A_TS:       readdata_d = TIMESTAMP;
        A_UP_LO: begin
          readdata_d = up_ext[31:0];
          snap_d     = up_ext[63:32];
        end
        A_UP_HI:    readdata_d = snap_q;
        A_CONTROL:  readdata_d = {31'd0, freeze_q};
        A_STATUS:   readdata_d = {31'd0, wrap_q};
        A_SCRATCH0: readdata_d = scratch0_q;
        A_SCRATCH1: readdata_d = scratch1_q;
        default:    readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_q <= 16'd0;
      uptime_q   <= '0;
      snap_q     <= 32'd0;
      freeze_q   <= 1'b0;
      wrap_q     <= 1'b0;
      scratch0_q <= 32'd0;
      scratch1_q <= 32'd0;
      readdata_q <= 32'd0;
      rdv_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      prescale_q <= prescale_d;
      uptime_q   <= uptime_d;
      snap_q     <= snap_d;
      freeze_q   <= freeze_d;
      wrap_q     <= wrap_d;
      scratch0_q <= scratch0_d;
      scratch1_q <= scratch1_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      tick_q     <= tick_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign tick          = tick_q;

endmodule

// File: tb/tb_sysid_uptime.sv
// Directed self-checking bench for sysid_uptime (CLK_DIV=4, 48-bit uptime);
// boundary counter values are preloaded hierarchically to reach wraps quickly.
module tb_sysid_uptime;

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        tick;

  int total;
  int bad;

  sysid_uptime #(
    .ID           (32'h4D09_E0CE),
    .TIMESTAMP    (32'h4B8A_1234),
    .UPTIME_WIDTH (48),
    .CLK_DIV      (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .tick          (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read issued in the current cycle; data checked one cycle later.
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    read    = 1'b1;
    write   = 1'b0;
    address = a;
    @(negedge clock);
    read = 1'b0;
    $display("rd  addr=%0d data=%h valid=%0b", a, readdata, readdatavalid);
    chk({tag, "_valid"}, {63'd0, readdatavalid}, 64'd1);
    chk(tag, {32'd0, readdata}, {32'd0, exp});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    write     = 1'b1;
    read      = 1'b0;
    address   = a;
    writedata = d;
    @(negedge clock);
    write = 1'b0;
    $display("wr  addr=%0d data=%h", a, d);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    address   = 3'd0;
    read      = 1'b0;
    write     = 1'b0;
    writedata = 32'd0;

    repeat (2) @(negedge clock);
    chk("rst_readdata", {32'd0, readdata}, 64'd0);
    chk("rst_valid", {63'd0, readdatavalid}, 64'd0);
    chk("rst_tick", {63'd0, tick}, 64'd0);
    reset = 1'b0;

    // Register map straight after reset, back-to-back reads.
    rd(3'd0, 32'h4D09_E0CE, "id");
    rd(3'd1, 32'h4B8A_1234, "timestamp");
    rd(3'd2, 32'd0, "uptime_lo_rst");
    rd(3'd3, 32'd0, "uptime_hi_rst");
    rd(3'd4, 32'd0, "control_rst");
    rd(3'd5, 32'd0, "status_rst");
    rd(3'd6, 32'd0, "scratch0_rst");
    rd(3'd7, 32'd0, "scratch1_rst");
    @(negedge clock);
    chk("valid_one_cycle", {63'd0, readdatavalid}, 64'd0);
    chk("readdata_hold", {32'd0, readdata}, 64'd0);

    // 40 cycles at CLK_DIV=4: tick every 4th cycle, uptime reaches 10.
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      chk($sformatf("tick_c%0d", k), {63'd0, tick}, {63'd0, (k % 4 == 0)});
    end
    rd(3'd2, 32'd10, "uptime_40cyc");
    chk("tick_after_read", {63'd0, tick}, 64'd0);

    // Low-word wrap into the high half: coherent snapshot of the pre-increment value.
    dut.uptime_q   = 48'h0000_FFFF_FFFF;
    dut.prescale_q = 16'd3;
    rd(3'd2, 32'hFFFF_FFFF, "lo_on_wrap");
    chk("tick_on_wrap", {63'd0, tick}, 64'd1);
    rd(3'd3, 32'd0, "hi_on_wrap");
    rd(3'd2, 32'd0, "lo_after_wrap");
    rd(3'd3, 32'd1, "hi_after_wrap");

    // Full counter wrap sets sticky WRAP.
    dut.uptime_q   = 48'hFFFF_FFFF_FFFF;
    dut.prescale_q = 16'd3;
    @(negedge clock);
    rd(3'd5, 32'd1, "status_wrap");
    // Second wrap coincident with write-1-clear: set wins.
    dut.uptime_q   = 48'hFFFF_FFFF_FFFF;
    dut.prescale_q = 16'd3;
    wr(3'd5, 32'd1);
    rd(3'd5, 32'd1, "status_set_wins");
    wr(3'd5, 32'd1);
    rd(3'd5, 32'd0, "status_cleared");

    // FREEZE written in the increment cycle holds the counter from that cycle on.
    dut.uptime_q   = 48'h0000_0000_1234;
    dut.prescale_q = 16'd3;
    wr(3'd4, 32'd1);
    chk("freeze_tick_c0", {63'd0, tick}, 64'd0);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      chk($sformatf("freeze_tick_c%0d", k), {63'd0, tick}, 64'd0);
    end
    rd(3'd2, 32'h0000_1234, "uptime_frozen");
    rd(3'd4, 32'd1, "control_freeze");
    wr(3'd4, 32'd2);
    rd(3'd4, 32'd0, "control_after_clear");
    rd(3'd2, 32'd0, "uptime_cleared");
    repeat (2) @(negedge clock);
    chk("tick_resumed", {63'd0, tick}, 64'd1);
    rd(3'd2, 32'd1, "uptime_resumed");

    // Read-only registers ignore writes.
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, 32'h4D09_E0CE, "id_ro");

    // Scratch registers and read+write collision.
    wr(3'd6, 32'hA5A5_5A5A);
    wr(3'd7, 32'h1234_5678);
    rd(3'd6, 32'hA5A5_5A5A, "scratch0");
    rd(3'd7, 32'h1234_5678, "scratch1");
    read      = 1'b1;
    write     = 1'b1;
    address   = 3'd6;
    writedata = 32'hDEAD_BEEF;
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    $display("rdwr addr=6 data=%h valid=%0b", writedata, readdatavalid);
    chk("rdwr_no_valid", {63'd0, readdatavalid}, 64'd0);
    rd(3'd6, 32'hDEAD_BEEF, "scratch0_rdwr");

    // Reset while a read is outstanding.
    read    = 1'b1;
    address = 3'd7;
    @(posedge clock);
    #1;
    reset = 1'b1;
    read  = 1'b0;
    #1;
    chk("midread_valid", {63'd0, readdatavalid}, 64'd0);
    chk("midread_data", {32'd0, readdata}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_valid", {63'd0, readdatavalid}, 64'd0);
    rd(3'd6, 32'd0, "scratch0_reset");
    rd(3'd7, 32'd0, "scratch1_reset");
    rd(3'd3, 32'd0, "snapshot_reset");
    rd(3'd5, 32'd0, "status_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
